// File: rtl/jt51_wrseq_pkg.sv
// Shared types and constants for the jt51 host write sequencer.
// Provides the FSM encoding, the {register, value} pair layout and register numbers.
package jt51_wrseq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_WSET = 3'd4;
  localparam logic [2:0] ST_WCLR = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    GAP  = ST_GAP,
    DATA = ST_DATA,
    WSET = ST_WSET,
    WCLR = ST_WCLR
  } state_e;

  localparam logic [7:0] KON  = 8'h08;
  localparam logic [7:0] LFRQ = 8'h18;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_pair_t;

  function automatic wr_pair_t makePair(input logic [7:0] a, input logic [7:0] d);
    wr_pair_t p;
    p.addr = a;
    p.data = d;
    return p;
  endfunction

endpackage

// File: rtl/jt51_wrseq_if.sv
// Bundle of host request signals and jt51 register-file strobes around the sequencer.
// The slave modport is the sequencer; master is the host plus register file side.
interface jt51_wrseq_if #(parameter int AW = 3);
  logic          req_we;
  logic [7:0]    req_addr;
  logic [7:0]    req_data;
  logic          req_full;
  logic [AW:0]   req_level;
  logic          ovf;
  logic          ovf_clr;
  logic          done;
  logic          idle;
  logic [7:0]    mmr_din;
  logic          mmr_a0;
  logic          mmr_write;
  logic          mmr_busy;

  modport master (
    output req_we, req_addr, req_data, ovf_clr, mmr_busy,
    input  req_full, req_level, ovf, done, idle, mmr_din, mmr_a0, mmr_write
  );

  modport slave (
    input  req_we, req_addr, req_data, ovf_clr, mmr_busy,
    output req_full, req_level, ovf, done, idle, mmr_din, mmr_a0, mmr_write
  );
endinterface

// File: rtl/jt51_wrseq_fifo.sv
// Small 16-bit FIFO holding queued {register, value} pairs.
// Head is read combinationally; only pointers and level are reset.
module jt51_wrseq_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 2**AW;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   level_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointers wrap naturally; level is tracked separately so full and empty stay distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/jt51_wrseq.sv
// Replays queued {register, value} pairs to the jt51 register file as address/data writes,
// skipping the address phase on a repeated register and waiting out the busy flag.
module jt51_wrseq
  import jt51_wrseq_pkg::*;
#(
  parameter int AW      = 3,
  parameter int BUSY_TO = 3
) (
  input logic          clk,
  input logic          rst,
  jt51_wrseq_if.slave  bus
);
  localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;
  logic          pop;
  logic [7:0]    curAddr_q, curData_q, lastAddr_q;
  logic          lastVld_q;
  logic          mmrWrite_q, mmrA0_q;
  logic [7:0]    mmrDin_q;
  logic          ovf_q;
  logic [15:0]   fifoRdata;
  logic [AW:0]   fifoLevel;
  logic          fifoFull, fifoEmpty;
  wr_pair_t      head;

  jt51_wrseq_fifo #(.AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.req_we),
    .pop_i   (pop),
    .wdata_i (makePair(bus.req_addr, bus.req_data)),
    .rdata_o (fifoRdata),
    .level_o (fifoLevel),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign head = wr_pair_t'(fifoRdata);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty && !bus.mmr_busy) begin
          pop     = 1'b1;
          state_d = (lastVld_q && head.addr == lastAddr_q) ? DATA : ADDR;
        end
      end
      ADDR: state_d = GAP;
      GAP:  state_d = DATA;
      DATA: begin
        state_d = WSET;
        timer_d = '0;
      end
      // A missed busy pulse must not stall the queue, hence the timeout.
      WSET: begin
        if (bus.mmr_busy || timer_q == TW'(BUSY_TO - 1)) state_d = WCLR;
        else timer_d = timer_q + 1'b1;
      end
      WCLR: begin
        if (!bus.mmr_busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      done_q    <= 1'b0;
      curAddr_q <= '0;
      curData_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      if (pop) begin
        curAddr_q <= head.addr;
        curData_q <= head.data;
      end
    end
  end

  // Strobes are registered from the current state, so each phase appears one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmrWrite_q <= 1'b0;
      mmrA0_q    <= 1'b0;
      mmrDin_q   <= '0;
      lastAddr_q <= '0;
      lastVld_q  <= 1'b0;
    end else begin
      mmrWrite_q <= (state_q == ADDR) || (state_q == DATA);
      if (state_q == ADDR) begin
        mmrA0_q    <= 1'b0;
        mmrDin_q   <= curAddr_q;
        lastAddr_q <= curAddr_q;
        lastVld_q  <= 1'b1;
      end else if (state_q == DATA) begin
        mmrA0_q  <= 1'b1;
        mmrDin_q <= curData_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (bus.req_we && fifoFull) ovf_q <= 1'b1;
    else if (bus.ovf_clr) ovf_q <= 1'b0;
  end

  assign bus.req_full  = fifoFull;
  assign bus.req_level = fifoLevel;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;
  assign bus.idle      = (state_q == IDLE) && fifoEmpty;
  assign bus.mmr_din   = mmrDin_q;
  assign bus.mmr_a0    = mmrA0_q;
  assign bus.mmr_write = mmrWrite_q;
endmodule

// File: doc/jt51_wrseq.md
Name: jt51_wrseq

Overview:
- Host-side write sequencer in front of the jt51 memory-mapped register file.
- Accepts {register, value} pairs from a CPU or soft-player into a small FIFO, then replays each pair as an address write (a0=0) followed by a data write (a0=1).
- After each data write it waits for the register-file busy flag to rise and clear before issuing the next pair.
- It skips the address phase when the register equals the last one addressed, and flags FIFO overflow.

Parameters:
- AW, 3: FIFO address width; depth = 2**AW entries.
- BUSY_TO, 3: clocks to wait for mmr_busy to rise after a data write before assuming it was missed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_we  in  1  push strobe, one entry per clock high
- req_addr  in  8  register number to write
- req_data  in  8  value to write
- req_full  out  1  FIFO holds 2**AW entries (combinational from count)
- req_level  out  AW+1  current entry count
- ovf  out  1  sticky: a push arrived while full
- ovf_clr  in  1  clears ovf
- done  out  1  one-clock pulse when a pair completes (busy released)
- idle  out  1  FIFO empty and FSM in IDLE
- mmr_din  out  8  to register-file din
- mmr_a0  out  1  to register-file a0
- mmr_write  out  1  to register-file write
- mmr_busy  in  1  from register-file busy

Behaviour:
- Reset values: FIFO empty, level 0, ovf 0, done 0, idle 1, mmr_write 0, mmr_a0 0, mmr_din 0, last_vld 0, state IDLE. Reset mid-transfer drops mmr_write asynchronously and discards queued entries.
- FIFO push: req_we with level<2**AW stores the entry on that edge.
  - With level==2**AW, the entry is dropped and ovf is set, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves level unchanged.
- ovf_clr and a set in the same cycle: set wins.
- All mmr_* outputs are registered.
- FSM states: IDLE, ADDR, GAP, DATA, WSET, WCLR.
- IDLE:
  - If level>0 and mmr_busy==0, pop the head entry into {cur_addr, cur_data}.
  - If last_vld and cur_addr==last_addr, go to DATA; otherwise go to ADDR.
- ADDR: exactly one clock with mmr_write=1, mmr_a0=0, mmr_din=cur_addr. Sets last_addr=cur_addr and last_vld=1. Next state is GAP.
- GAP: exactly one clock with mmr_write=0. This is mandatory because the register file arms busy only on a rising edge of write with a0=1. Next state is DATA.
- DATA: exactly one clock with mmr_write=1, mmr_a0=1, mmr_din=cur_data. Next state is WSET.
- WSET:
  - mmr_write=0, so write is low for at least one clock after every data phase.
  - Go to WCLR when mmr_busy==1, or after BUSY_TO clocks in WSET (timeout).
- WCLR: wait for mmr_busy==0, then pulse done for one clock and return to IDLE.
- Latency with an empty FIFO, idle FSM and a new address:
  - Push on edge k.
  - ADDR drive occupies k+2..k+3.
  - DATA drive occupies k+4..k+5.
- With a repeated address, the DATA drive occupies k+2..k+3.
- Back-to-back pairs: the next ADDR starts no earlier than 2 clocks after busy falls.
- mmr_a0 and mmr_din hold their last values outside write phases. Only mmr_write is a qualifier.
- FIFO pointers wrap modulo 2**AW; level is a separate counter, AW+1 bits wide.
- idle = (state==IDLE) && (level==0).

Decomposition:
- Constants go in the shared jt51 package: state encoding (3-bit localparams for IDLE..WCLR) and the mmr register-address constants (e.g. KON=8'h08, LFRQ=8'h18) used by benches.
- One natural sub-module: jt51_wrseq_fifo.
  - Parameterised AW, 16-bit wide, synchronous push/pop, level output.
  - No storage reset beyond pointers and level.
- Everything else stays in jt51_wrseq.

Test Plan:
- Single pair, register-file model:
  - Stimulus: push {8'h20,8'hC7}; model raises busy 1 clock after the data write and holds it 32 clocks.
  - Expect: write, a0=0, din=20 for 1 clock; 1 low clock; write, a0=1, din=C7 for 1 clock; done pulses 1 clock after busy falls; idle=1.
- Address skip:
  - Stimulus: push {08,00} then {08,78}.
  - Expect: second pair issues only the DATA phase, with no a0=0 write; two done pulses total.
- Overflow with AW=3:
  - Stimulus: hold mmr_busy=1 and push 9 entries.
  - Expect: req_full=1 after 8 pushes; the 9th sets ovf; level stays 8; after ovf_clr, ovf=0.
  - Release busy: exactly the first 8 pairs replay in order.
- Busy timeout:
  - Stimulus: model never raises busy.
  - Expect: FSM leaves WSET after 3 clocks; done pulses; the next pair proceeds.
- Reset mid-transfer:
  - Stimulus: assert rst during the DATA clock.
  - Expect: mmr_write=0 immediately; level=0, idle=1, ovf=0; the first push after reset issues the ADDR phase even for the previously used register (last_vld cleared).
